// File: rtl/d_mem_arbiter_2p.sv
// -----------------------------------------------------------------------------
// d_mem_arbiter_2p
//
// Shares one single-port data memory between two masters: the CPU data port
// (m0) and a loader/debug port (m1). Both sides use the
// d_req/d_dir/d_addr/d_wdata/d_ack/d_rdata handshake.
//
// A grant is held until the memory acks, or until the granted master drops
// its request. The arbiter then spends one GAP cycle with s_req low, so the
// memory's registered ready flag clears before the next grant. Contention is
// resolved round-robin against the last granted master.
//
// Ports
//   clk, rst_n                 system clock, async active-low reset
//   m0_req/dir/addr/wdata      master 0 request (level, held until m0_ack)
//   m0_ack, m0_rdata           master 0 completion; rdata valid while ack=1
//   m1_*                       same for master 1
//   s_req/dir/addr/wdata       request towards the memory
//   s_ack, s_rdata             memory completion and read data
//   busy                       high whenever the arbiter is not IDLE
//
// dir is forwarded unchanged in the team DIRECTION_READ/DIRECTION_WRITE
// encoding. Write enable is left to the memory; the arbiter never gates it.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no transaction; arbitrate incoming requests
// BUSY0 | m0 owns the memory; s_* driven from m0, ack passed to m0
// BUSY1 | m1 owns the memory; s_* driven from m1, ack passed to m1
// GAP   | one cycle with s_req=0 after a transaction; arbitrate as in IDLE
// -----------------------------------------------------------------------------
module d_mem_arbiter_2p #(
  parameter int d_addr_width = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,

  input  logic                    m0_req,
  input  logic                    m0_dir,
  input  logic [d_addr_width-1:0] m0_addr,
  input  logic [7:0]              m0_wdata,
  output logic                    m0_ack,
  output logic [7:0]              m0_rdata,

  input  logic                    m1_req,
  input  logic                    m1_dir,
  input  logic [d_addr_width-1:0] m1_addr,
  input  logic [7:0]              m1_wdata,
  output logic                    m1_ack,
  output logic [7:0]              m1_rdata,

  output logic                    s_req,
  output logic                    s_dir,
  output logic [d_addr_width-1:0] s_addr,
  output logic [7:0]              s_wdata,
  input  logic                    s_ack,
  input  logic [7:0]              s_rdata,

  output logic                    busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY0 = 2'd1,
    ST_BUSY1 = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  state_e state_q, state_d;
  logic   last_grant_q, last_grant_d;

  // Arbitration result, used from IDLE and GAP.
  // arb_pick: 0 selects m0, 1 selects m1.
  logic arb_valid;
  logic arb_pick;

  always_comb begin
    arb_valid = m0_req | m1_req;
    arb_pick  = 1'b0;
    if (m0_req && m1_req) begin
      // Tie: serve whoever did not get the previous grant.
      arb_pick = ~last_grant_q;
    end else if (m1_req) begin
      arb_pick = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // State and last-grant registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      // Reset as if m1 had the last grant so m0 wins the first tie.
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;

    case (state_q)
      ST_IDLE, ST_GAP: begin
        if (arb_valid) begin
          state_d      = arb_pick ? ST_BUSY1 : ST_BUSY0;
          last_grant_d = arb_pick;
        end else begin
          state_d = ST_IDLE;
        end
      end

      // A completing ack and a dropped request both end the grant. A dropped
      // request is abandoned without an ack; either way GAP follows, so the
      // memory sees s_req low before the next owner.
      ST_BUSY0: begin
        if (s_ack || !m0_req) begin
          state_d = ST_GAP;
        end
      end

      ST_BUSY1: begin
        if (s_ack || !m1_req) begin
          state_d = ST_GAP;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs: combinational from the state register, so an async reset clears
  // them immediately.
  // ---------------------------------------------------------------------------
  always_comb begin
    s_req   = 1'b0;
    s_dir   = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    m0_ack  = 1'b0;
    m1_ack  = 1'b0;

    case (state_q)
      ST_BUSY0: begin
        s_req   = 1'b1;
        s_dir   = m0_dir;
        s_addr  = m0_addr;
        s_wdata = m0_wdata;
        m0_ack  = s_ack;
      end

      ST_BUSY1: begin
        s_req   = 1'b1;
        s_dir   = m1_dir;
        s_addr  = m1_addr;
        s_wdata = m1_wdata;
        m1_ack  = s_ack;
      end

      default: begin
      end
    endcase
  end

  // Read data is broadcast; each master qualifies it with its own ack.
  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;

  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_d_mem_arbiter_2p.sv
module tb_d_mem_arbiter_2p;

  localparam int   AW        = 8;
  localparam logic DIR_READ  = 1'b0;
  localparam logic DIR_WRITE = 1'b1;
  localparam int   N_RND     = 40;

  logic          clk;
  logic          rst_n;
  logic          m0_req, m0_dir, m0_ack;
  logic [AW-1:0] m0_addr;
  logic [7:0]    m0_wdata, m0_rdata;
  logic          m1_req, m1_dir, m1_ack;
  logic [AW-1:0] m1_addr;
  logic [7:0]    m1_wdata, m1_rdata;
  logic          s_req, s_dir, s_ack;
  logic [AW-1:0] s_addr;
  logic [7:0]    s_wdata, s_rdata;
  logic          busy;

  int n_checks;
  int n_pass;

  d_mem_arbiter_2p #(.d_addr_width(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .m0_req   (m0_req),
    .m0_dir   (m0_dir),
    .m0_addr  (m0_addr),
    .m0_wdata (m0_wdata),
    .m0_ack   (m0_ack),
    .m0_rdata (m0_rdata),
    .m1_req   (m1_req),
    .m1_dir   (m1_dir),
    .m1_addr  (m1_addr),
    .m1_wdata (m1_wdata),
    .m1_ack   (m1_ack),
    .m1_rdata (m1_rdata),
    .s_req    (s_req),
    .s_dir    (s_dir),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_ack    (s_ack),
    .s_rdata  (s_rdata),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port memory with a registered ready flag: it acks one cycle after
  // it first sees req, and needs to see req low before it can ack again.
  logic [7:0]    tb_mem [256];
  logic          mem_ready_q;
  logic [7:0]    mem_rdata_q;
  logic          mem_stall;
  logic          mem_rand_lat;
  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [7:0]    pl_data;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_ready_q <= 1'b0;
      mem_rdata_q <= 8'h00;
    end else begin
      if (pl_en) tb_mem[pl_addr] = pl_data;
      if (s_req && !mem_ready_q) begin
        if (!mem_stall && (!mem_rand_lat || ($urandom_range(0, 1) == 1))) begin
          mem_ready_q <= 1'b1;
          if (s_dir == DIR_WRITE) tb_mem[s_addr] = s_wdata;
          else                    mem_rdata_q <= tb_mem[s_addr];
        end
      end else begin
        mem_ready_q <= 1'b0;
      end
    end
  end

  assign s_ack   = mem_ready_q;
  assign s_rdata = mem_rdata_q;

  task automatic idle_inputs();
    m0_req = 0; m0_dir = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_dir = 0; m1_addr = '0; m1_wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    mem_stall = 0; mem_rand_lat = 0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [7:0] d);
    pl_en = 1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 0;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    idle_inputs();
    mem_stall = 0; mem_rand_lat = 0;
    rst_n = 0;
    #3;
    n_checks++; if (s_req !== 1'b0) $display("FAIL rst_s_req got=%b exp=0", s_req); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy); else n_pass++;
    n_checks++; if ({m0_ack, m1_ack} !== 2'b00) $display("FAIL rst_acks got=%b exp=00", {m0_ack, m1_ack}); else n_pass++;
    n_checks++; if ({s_dir, s_addr, s_wdata} !== '0) $display("FAIL rst_s_bus got=%h exp=0", {s_dir, s_addr, s_wdata}); else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_idle_busy got=%b exp=0", busy); else n_pass++;
  endtask

  // Cycle k below means the k-th negedge after the edge that first sees req.
  task automatic test_single_read();
    do_reset();
    preload(8'h05, 8'hA5);
    m0_req = 1; m0_dir = DIR_READ; m0_addr = 8'h05;
    @(negedge clk);
    n_checks++; if ({s_req, busy, m0_ack} !== 3'b110) $display("FAIL rd_c1 got req/busy/ack=%b exp=110", {s_req, busy, m0_ack}); else n_pass++;
    n_checks++; if (s_addr !== 8'h05) $display("FAIL rd_c1_addr got=%h exp=05", s_addr); else n_pass++;
    @(negedge clk);
    n_checks++; if (m0_ack !== 1'b1) $display("FAIL rd_c2_ack got=%b exp=1", m0_ack); else n_pass++;
    n_checks++; if (m0_rdata !== 8'hA5) $display("FAIL rd_c2_rdata got=%h exp=a5", m0_rdata); else n_pass++;
    n_checks++; if (m1_ack !== 1'b0) $display("FAIL rd_c2_m1ack got=%b exp=0", m1_ack); else n_pass++;
    m0_req = 0;
    @(negedge clk);
    n_checks++; if ({s_req, busy, m0_ack} !== 3'b010) $display("FAIL rd_c3_gap got req/busy/ack=%b exp=010", {s_req, busy, m0_ack}); else n_pass++;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL rd_c4_idle got=%b exp=0", busy); else n_pass++;
  endtask

  task automatic test_write_read();
    do_reset();
    m1_req = 1; m1_dir = DIR_WRITE; m1_addr = 8'h10; m1_wdata = 8'h3C;
    @(negedge clk);
    n_checks++; if ({s_req, s_dir, s_wdata} !== {1'b1, DIR_WRITE, 8'h3C}) $display("FAIL wr_c1 got=%h exp=%h", {s_req, s_dir, s_wdata}, {1'b1, DIR_WRITE, 8'h3C}); else n_pass++;
    @(negedge clk);
    n_checks++; if ({m1_ack, m0_ack} !== 2'b10) $display("FAIL wr_c2_ack got=%b exp=10", {m1_ack, m0_ack}); else n_pass++;
    m1_dir = DIR_READ; m1_wdata = 8'h00;
    @(negedge clk);
    n_checks++; if ({s_req, m1_ack} !== 2'b00) $display("FAIL wr_gap got=%b exp=00", {s_req, m1_ack}); else n_pass++;
    @(negedge clk);
    n_checks++; if ({s_req, s_dir, m1_ack} !== {1'b1, DIR_READ, 1'b0}) $display("FAIL rd2_c4 got=%b exp=100", {s_req, s_dir, m1_ack}); else n_pass++;
    @(negedge clk);
    n_checks++; if (m1_ack !== 1'b1) $display("FAIL rd2_ack got=%b exp=1", m1_ack); else n_pass++;
    n_checks++; if (m1_rdata !== 8'h3C) $display("FAIL rd2_rdata got=%h exp=3c", m1_rdata); else n_pass++;
    m1_req = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_contention();
    int acks0, acks1;
    logic e0, e1;
    do_reset();
    preload(8'h40, 8'h11);
    preload(8'h41, 8'h22);
    acks0 = 0; acks1 = 0;
    m0_req = 1; m0_dir = DIR_READ; m0_addr = 8'h40;
    m1_req = 1; m1_dir = DIR_READ; m1_addr = 8'h41;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      // Period of 6: BUSY0, ack0, GAP, BUSY1, ack1, GAP.
      e0 = (k % 6 == 2);
      e1 = (k % 6 == 5);
      n_checks++; if ({m0_ack, m1_ack} !== {e0, e1}) $display("FAIL cont_ack k=%0d got=%b exp=%b", k, {m0_ack, m1_ack}, {e0, e1}); else n_pass++;
      n_checks++; if (s_req !== (k % 3 != 0)) $display("FAIL cont_sreq k=%0d got=%b exp=%b", k, s_req, (k % 3 != 0)); else n_pass++;
      if (m0_ack) begin
        acks0++;
        n_checks++; if (m0_rdata !== 8'h11) $display("FAIL cont_rdata0 got=%h exp=11", m0_rdata); else n_pass++;
        if (acks0 == 4) m0_req = 0;
      end
      if (m1_ack) begin
        acks1++;
        n_checks++; if (m1_rdata !== 8'h22) $display("FAIL cont_rdata1 got=%h exp=22", m1_rdata); else n_pass++;
        if (acks1 == 4) m1_req = 0;
      end
    end
    n_checks++; if (acks0 + acks1 !== 8) $display("FAIL cont_total got=%0d exp=8", acks0 + acks1); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_nongranted_stable();
    do_reset();
    m0_req = 1; m0_dir = DIR_READ; m0_addr = 8'h20;
    @(negedge clk);
    n_checks++; if (s_addr !== 8'h20) $display("FAIL ng_c1_addr got=%h exp=20", s_addr); else n_pass++;
    m1_req = 1; m1_dir = DIR_READ; m1_addr = 8'h30;
    #1;
    n_checks++; if (s_addr !== 8'h20) $display("FAIL ng_c1b_addr got=%h exp=20", s_addr); else n_pass++;
    @(negedge clk);
    n_checks++; if (s_addr !== 8'h20) $display("FAIL ng_c2_addr got=%h exp=20", s_addr); else n_pass++;
    n_checks++; if ({m0_ack, m1_ack} !== 2'b10) $display("FAIL ng_c2_ack got=%b exp=10", {m0_ack, m1_ack}); else n_pass++;
    m0_req = 0;
    @(negedge clk);
    n_checks++; if (s_req !== 1'b0) $display("FAIL ng_c3_gap got=%b exp=0", s_req); else n_pass++;
    @(negedge clk);
    n_checks++; if ({s_req, s_addr} !== {1'b1, 8'h30}) $display("FAIL ng_c4_grant got=%h exp=130", {s_req, s_addr}); else n_pass++;
    @(negedge clk);
    n_checks++; if (m1_ack !== 1'b1) $display("FAIL ng_c5_ack got=%b exp=1", m1_ack); else n_pass++;
    m1_req = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_abandon();
    do_reset();
    mem_stall = 1;
    m0_req = 1; m0_dir = DIR_READ; m0_addr = 8'h07;
    @(negedge clk);
    n_checks++; if (s_req !== 1'b1) $display("FAIL ab_c1 got=%b exp=1", s_req); else n_pass++;
    @(negedge clk);
    n_checks++; if ({s_req, m0_ack} !== 2'b10) $display("FAIL ab_c2 got=%b exp=10", {s_req, m0_ack}); else n_pass++;
    m0_req = 0;
    m1_req = 1; m1_dir = DIR_READ; m1_addr = 8'h08;
    @(negedge clk);
    n_checks++; if ({s_req, busy, m0_ack, m1_ack} !== 4'b0100) $display("FAIL ab_gap got=%b exp=0100", {s_req, busy, m0_ack, m1_ack}); else n_pass++;
    mem_stall = 0;
    @(negedge clk);
    n_checks++; if ({s_req, s_addr} !== {1'b1, 8'h08}) $display("FAIL ab_m1_grant got=%h exp=108", {s_req, s_addr}); else n_pass++;
    @(negedge clk);
    n_checks++; if ({m0_ack, m1_ack} !== 2'b01) $display("FAIL ab_m1_ack got=%b exp=01", {m0_ack, m1_ack}); else n_pass++;
    m1_req = 0;
    repeat (2) @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL ab_idle got=%b exp=0", busy); else n_pass++;
  endtask

  task automatic test_async_reset();
    do_reset();
    m1_req = 1; m1_dir = DIR_WRITE; m1_addr = 8'h50; m1_wdata = 8'h77;
    @(negedge clk);
    n_checks++; if ({s_req, busy} !== 2'b11) $display("FAIL ar_c1 got=%b exp=11", {s_req, busy}); else n_pass++;
    @(negedge clk);
    n_checks++; if (m1_ack !== 1'b1) $display("FAIL ar_c2_ack got=%b exp=1", m1_ack); else n_pass++;
    #2 rst_n = 0;
    #1;
    n_checks++; if ({s_req, m1_ack, busy} !== 3'b000) $display("FAIL ar_immediate got=%b exp=000", {s_req, m1_ack, busy}); else n_pass++;
    n_checks++; if (s_addr !== 8'h00) $display("FAIL ar_addr got=%h exp=00", s_addr); else n_pass++;
    m0_req = 1; m0_dir = DIR_READ; m0_addr = 8'h60;
    m1_dir = DIR_READ;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    n_checks++; if ({s_req, s_addr} !== {1'b1, 8'h60}) $display("FAIL ar_first_m0 got=%h exp=160", {s_req, s_addr}); else n_pass++;
    @(negedge clk);
    n_checks++; if ({m0_ack, m1_ack} !== 2'b10) $display("FAIL ar_m0_ack got=%b exp=10", {m0_ack, m1_ack}); else n_pass++;
    m0_req = 0;
    repeat (2) @(negedge clk);
    n_checks++; if ({s_req, s_addr} !== {1'b1, 8'h50}) $display("FAIL ar_then_m1 got=%h exp=150", {s_req, s_addr}); else n_pass++;
    @(negedge clk);
    m1_req = 0;
    repeat (2) @(negedge clk);
  endtask

  // Randomized traffic, random memory latency. Reference model: an array
  // standing for memory contents, updated in ack order; fairness expressed as
  // "a waiting master is overtaken at most once".
  task automatic test_random();
    logic [7:0] ref_mem [16];
    logic       req [2];
    logic       dir [2];
    logic [7:0] addr [2];
    logic [7:0] wdata [2];
    logic       ack [2];
    logic [7:0] rdat [2];
    int         done [2];
    int         idle [2];
    int         over [2];
    logic       prev_ack;

    do_reset();
    for (int a = 0; a < 16; a++) begin
      ref_mem[a] = 8'($urandom);
      preload(8'(a), ref_mem[a]);
    end
    mem_rand_lat = 1;
    for (int i = 0; i < 2; i++) begin
      req[i] = 0; dir[i] = 0; addr[i] = 0; wdata[i] = 0;
      done[i] = 0; idle[i] = 1; over[i] = 0;
    end
    prev_ack = 0;

    for (int cyc = 0; cyc < 6000; cyc++) begin
      if (done[0] == N_RND && done[1] == N_RND) break;
      @(negedge clk);
      ack[0] = m0_ack; ack[1] = m1_ack;
      rdat[0] = m0_rdata; rdat[1] = m1_rdata;

      if (prev_ack) begin
        n_checks++; if (s_req !== 1'b0) $display("FAIL rnd_gap cyc=%0d s_req=%b exp=0", cyc, s_req); else n_pass++;
      end
      n_checks++; if ((ack[0] & ack[1]) !== 1'b0) $display("FAIL rnd_excl cyc=%0d acks=%b%b exp not both", cyc, ack[0], ack[1]); else n_pass++;

      for (int i = 0; i < 2; i++) begin
        if (ack[i]) begin
          n_checks++; if (req[i] !== 1'b1) $display("FAIL rnd_ack_noreq m%0d cyc=%0d got ack without req", i, cyc); else n_pass++;
          n_checks++; if (s_addr !== addr[i]) $display("FAIL rnd_addr m%0d got=%h exp=%h", i, s_addr, addr[i]); else n_pass++;
          if (dir[i] == DIR_READ) begin
            n_checks++; if (rdat[i] !== ref_mem[addr[i][3:0]]) $display("FAIL rnd_rdata m%0d addr=%h got=%h exp=%h", i, addr[i], rdat[i], ref_mem[addr[i][3:0]]); else n_pass++;
          end else begin
            ref_mem[addr[i][3:0]] = wdata[i];
          end
          over[i] = 0;
          if (req[1-i]) begin
            over[1-i]++;
            n_checks++; if (over[1-i] > 1) $display("FAIL rnd_fair m%0d overtaken got=%0d exp<=1", 1-i, over[1-i]); else n_pass++;
          end
        end
      end
      prev_ack = ack[0] | ack[1];

      for (int i = 0; i < 2; i++) begin
        if (ack[i]) begin
          done[i]++;
          req[i] = 0;
          idle[i] = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 3);
        end else if (!req[i] && idle[i] > 0) begin
          idle[i]--;
        end
        if (!req[i] && idle[i] == 0 && done[i] < N_RND) begin
          req[i]   = 1;
          dir[i]   = 1'($urandom_range(0, 1));
          addr[i]  = 8'($urandom_range(0, 15));
          wdata[i] = 8'($urandom);
        end
      end
      m0_req = req[0]; m0_dir = dir[0]; m0_addr = addr[0]; m0_wdata = wdata[0];
      m1_req = req[1]; m1_dir = dir[1]; m1_addr = addr[1]; m1_wdata = wdata[1];
    end

    n_checks++; if (done[0] !== N_RND) $display("FAIL rnd_done_m0 got=%0d exp=%0d", done[0], N_RND); else n_pass++;
    n_checks++; if (done[1] !== N_RND) $display("FAIL rnd_done_m1 got=%0d exp=%0d", done[1], N_RND); else n_pass++;
    idle_inputs();
    mem_rand_lat = 0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    pl_en    = 0;
    pl_addr  = '0;
    pl_data  = '0;
    test_reset();
    test_single_read();
    test_write_read();
    test_contention();
    test_nongranted_stable();
    test_abandon();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/d_mem_arbiter_2p.md
Name: d_mem_arbiter_2p

Overview:
Two-requester arbiter that shares one single-port data memory, using the d_req/d_dir/d_addr/d_wdata/d_ack/d_rdata handshake, between two masters: the CPU data port (m0) and a loader/debug port (m1). Arbitration is round-robin on contention. The block locks the grant until the memory acks, then inserts one idle gap cycle so the memory's registered ready flag clears before the next transaction. It sits between the masters and the data memory instance.

Parameters:
d_addr_width, 8, width of every address bus.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
m0_req  input  1  master 0 request; level, held until m0_ack
m0_dir  input  1  master 0 direction, team DIRECTION_READ/DIRECTION_WRITE encoding
m0_addr  input  d_addr_width  master 0 address
m0_wdata  input  8  master 0 write data
m0_ack  output  1  master 0 transaction complete
m0_rdata  output  8  master 0 read data, valid only while m0_ack=1
m1_req, m1_dir, m1_addr, m1_wdata, m1_ack, m1_rdata  same widths/meaning for master 1
s_req  output  1  request to memory
s_dir  output  1  direction to memory
s_addr  output  d_addr_width  address to memory
s_wdata  output  8  write data to memory
s_ack  input  1  memory ack
s_rdata  input  8  memory read data
busy  output  1  high while state is not IDLE

Behaviour:
- States: IDLE, BUSY0, BUSY1, GAP. State register plus last_grant register.
- Reset (async, rst_n=0): state=IDLE, last_grant=1 so m0 wins the first tie. Reset takes effect immediately: s_req=0, m0_ack=m1_ack=0, busy=0, s_dir/s_addr/s_wdata=0.
- IDLE or GAP, arbitration:
  - Only m0_req=1: next state BUSY0.
  - Only m1_req=1: next state BUSY1.
  - Both: grant the master that is not last_grant.
  - Neither: next state IDLE.
- last_grant updates on entry to BUSYx.
- BUSYx outputs: s_req=1; s_dir/s_addr/s_wdata come combinationally from master x. Non-granted master sees ack=0.
- mx_ack = s_ack while state==BUSYx (combinational pass-through). m0_rdata=m1_rdata=s_rdata always; masters qualify with ack.
- BUSYx exit:
  - s_ack=1: next state GAP; the transaction completes on that edge.
  - mx_req drops before ack (protocol violation): abandon, next state GAP, no ack issued.
  - Otherwise remain in BUSYx with no timeout.
- GAP: s_req=0 for exactly one cycle, mx_ack=0, and arbitration runs as in IDLE. Purpose: the memory samples req=0, so its ready flag is 0 when the next grant raises s_req.
- Outside BUSYx: s_dir/s_addr/s_wdata=0. busy=1 in BUSY0, BUSY1 and GAP.
- Timing with the registered-ready memory: req seen at edge E0 → BUSY in cycle 1 → ack in cycle 2 → GAP in cycle 3 → next BUSY at the earliest in cycle 4. Per-master throughput is one transaction per 3 cycles; with both masters pending, grants alternate.
- Master holding req high after its ack: treated as a new request, arbitrated fairly in GAP.
- Writes: the arbiter forwards dir/wdata only. It never gates write enable itself.

Test Plan:
- Single read: memory preloaded [0x05]=0xA5; m0 reads addr 0x05 → s_req high cycle 1, m0_ack and m0_rdata=0xA5 in cycle 2, s_req=0 in cycle 3, m1_ack stays 0.
- Write then read: m1 writes 0x3C to 0x10, then reads 0x10 → m1_ack once per transaction, read returns 0x3C, gap cycle present between them.
- Contention fairness: m0 and m1 request simultaneously and hold for 4 transactions each → grant order m0,m1,m0,m1,… with exactly one GAP between BUSY states, no starvation, 8 acks total in 24 cycles.
- Non-granted master stable: m1 requests mid-way through an m0 transaction → m1 granted in the cycle after GAP begins arbitration (cycle 4 relative to the m0 start); s_addr never shows m1_addr while in BUSY0.
- Abandon: m0 drops req in BUSY0 before ack → no m0_ack, GAP for one cycle, then IDLE (or serve m1 if pending).
- Async reset mid-BUSY1: rst_n=0 asynchronously → s_req, m1_ack and busy go 0 immediately. After release with both requesting, m0 is granted first.
